// File: rtl/frame_buffer.sv
// Double-buffered pixel store: assembles SPI pixel frames in the back bank, serves the front bank to the scanner.
// Read latency 1 cycle, never stalled; banks swap only on a scanner frame boundary once a full back frame exists.
module frame_buffer #(
  parameter int COLS        = 32,
  parameter int ROW_PAIRS   = 16,
  parameter int FRAME_BYTES = COLS * ROW_PAIRS
) (
  input  logic                         i_clk,
  input  logic                         i_reset_n,
  input  logic                         i_wr_valid,
  input  logic [7:0]                   i_wr_data,
  input  logic [$clog2(ROW_PAIRS)-1:0] i_rd_row,
  input  logic [$clog2(COLS)-1:0]      i_rd_col,
  input  logic                         i_rd_frame_done,
  output logic [5:0]                   o_rd_data,
  output logic                         o_disp_bank,
  output logic                         o_swap_pending,
  output logic                         o_wr_busy,
  output logic                         o_frame_err
);

  localparam int AW = $clog2(FRAME_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_HOLD} state_t;

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_ptr, w_ptr_nxt;
  logic          r_disp_bank;
  logic          r_frame_err;
  logic [5:0]    r_rd_data;
  logic [5:0]    r_mem [0:2*FRAME_BYTES-1];

  logic          w_we;
  logic [AW-1:0] w_waddr;
  logic          w_err_nxt;
  logic          w_sof;
  logic          w_last;
  logic          w_swap;
  logic          w_unused;

  assign w_sof    = i_wr_data[7];
  assign w_last   = (r_ptr == AW'(FRAME_BYTES - 1));
  // Only a HOLD frame may swap, so a last byte coinciding with frame_done waits a frame.
  assign w_swap   = i_rd_frame_done && (r_state == S_HOLD);
  assign w_unused = i_wr_data[3];

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_we        = 1'b0;
    w_waddr     = r_ptr;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_wr_valid && w_sof) begin
          w_we        = 1'b1;
          w_waddr     = '0;
          w_ptr_nxt   = AW'(1);
          w_state_nxt = S_FILL;
        end
      end
      S_FILL: begin
        if (i_wr_valid) begin
          w_we = 1'b1;
          if (w_sof) begin
            w_waddr   = '0;
            w_ptr_nxt = AW'(1);
            w_err_nxt = 1'b1;
          end else if (w_last) begin
            w_state_nxt = S_HOLD;
          end else begin
            w_ptr_nxt = r_ptr + AW'(1);
          end
        end
      end
      S_HOLD: begin
        if (i_wr_valid && w_sof) w_err_nxt = 1'b1;
        if (w_swap) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_disp_bank <= 1'b0;
      r_frame_err <= 1'b0;
      r_rd_data   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_frame_err <= w_err_nxt;
      r_rd_data   <= r_mem[{r_disp_bank, i_rd_row, i_rd_col}];
      if (w_swap) r_disp_bank <= ~r_disp_bank;
    end
  end

  // Pixel RAM holds both banks; deliberately not cleared by reset.
  always_ff @(posedge i_clk) begin
    if (w_we) r_mem[{~r_disp_bank, w_waddr}] <= {i_wr_data[6:4], i_wr_data[2:0]};
  end

  assign o_rd_data      = r_rd_data;
  assign o_disp_bank    = r_disp_bank;
  assign o_swap_pending = (r_state == S_HOLD);
  assign o_wr_busy      = (r_state == S_FILL);
  assign o_frame_err    = r_frame_err;

endmodule
